// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
package mau_pkg;

    // Request size codes; SZ_BAD always faults.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    // Little-endian byte lanes within a 32-bit word.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mau_lane_merge.sv
// Lane handling: load extraction with sign/zero extension, and store merge
// of a sub-word into the word read back from memory.
module mau_lane_merge
    import mau_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sgn,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/half and extend it to 32 bits.
    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (lane)
            LANE_B0: byte_sel = rdata[7:0];
            LANE_B1: byte_sel = rdata[15:8];
            LANE_B2: byte_sel = rdata[23:16];
            LANE_B3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        case (size)
            SZ_BYTE: load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sgn & half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Overwrite only the addressed lane(s) of the old word.
    always_comb begin
        merged = rdata;
        if (size == SZ_BYTE) begin
            case (lane)
                LANE_B0: merged[7:0]   = wdata[7:0];
                LANE_B1: merged[15:8]  = wdata[7:0];
                LANE_B2: merged[23:16] = wdata[7:0];
                LANE_B3: merged[31:24] = wdata[7:0];
                default: merged        = rdata;
            endcase
        end else if (size == SZ_HALF) begin
            if (lane[1]) merged[31:16] = wdata;
            else         merged[15:0]  = wdata;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: accepts byte-addressed requests, checks them, and
// drives a word-addressed memory, using read-modify-write for sub-word stores.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_r_address,
    input  logic [31:0]       mem_r_data,
    output logic [ADDR_W-1:0] mem_w_address,
    output logic [31:0]       mem_w_data,
    output logic              mem_w_enable
);

    state_t            state, state_nxt;
    logic              lat_write;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [ADDR_W-1:0] lat_idx;
    logic [1:0]        lat_lane;
    logic [31:0]       lat_wdata;
    logic [31:0]       merged_q;
    logic              req_fault;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    mau_lane_merge u_lane (
        .rdata     (mem_r_data),
        .size      (lat_size),
        .lane      (lat_lane),
        .sgn       (lat_signed),
        .wdata     (lat_wdata[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    // Alignment, size and range check on the incoming request.
    always_comb begin
        req_fault = 1'b0;
        if (req_size == SZ_BAD)                         req_fault = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])         req_fault = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_fault = 1'b1;
        if (req_addr[31:ADDR_W+2] != '0)                req_fault = 1'b1;
    end

    // Next-state logic and memory-side outputs.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_fault ? RESP : ACCESS;
            ACCESS:  state_nxt = (lat_write && lat_size != SZ_WORD) ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready     = (state == IDLE);
    assign resp_valid    = (state == RESP);
    assign mem_r_address = lat_idx;
    assign mem_w_address = lat_idx;
    assign mem_w_data    = (state == WRITE) ? merged_q : lat_wdata;
    // Gating with rst drops a write that would otherwise land on the reset edge.
    assign mem_w_enable  = !rst && ((state == WRITE) ||
                           (state == ACCESS && lat_write && lat_size == SZ_WORD));

    // State, request latches and response registers; everything holds while clk_enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_write  <= 1'b0;
            lat_size   <= 2'd0;
            lat_signed <= 1'b0;
            lat_idx    <= '0;
            lat_lane   <= 2'd0;
            lat_wdata  <= 32'd0;
            merged_q   <= 32'd0;
            resp_data  <= 32'd0;
            resp_fault <= 1'b0;
        end else if (clk_enable) begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_idx    <= req_addr[ADDR_W+1:2];
                        lat_lane   <= req_addr[1:0];
                        lat_wdata  <= req_wdata;
                        resp_data  <= 32'd0;
                        resp_fault <= req_fault;
                    end
                end
                ACCESS: begin
                    if (!lat_write) resp_data <= load_data;
                    merged_q <= merged;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data_mem model.
module tb_mem_access_unit;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clk_enable = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_signed = 1'b0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_r_address;
    logic [31:0]       mem_r_data;
    logic [ADDR_W-1:0] mem_w_address;
    logic [31:0]       mem_w_data;
    logic              mem_w_enable;

    logic [31:0] mem [0:255];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_fault(resp_fault), .mem_r_address(mem_r_address),
        .mem_r_data(mem_r_data), .mem_w_address(mem_w_address),
        .mem_w_data(mem_w_data), .mem_w_enable(mem_w_enable)
    );

    assign mem_r_data = mem[mem_r_address];
    always @(posedge clk) if (clk_enable && mem_w_enable) mem[mem_w_address] <= mem_w_data;

    // Issue one request from IDLE; report latency (cycles after accept edge), result and writes.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] data, output logic flt,
                          output int nw, output logic [ADDR_W-1:0] wa);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nw = 0; wa = '0; data = 32'hx; flt = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_w_enable && clk_enable) begin nw++; wa = mem_w_address; end
            if (resp_valid) begin lat = k; data = resp_data; flt = resp_fault; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", resp_data); end
        checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", resp_fault); end
        checks++; if (mem_w_enable !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", mem_w_enable); end
        checks++; if (mem_r_address !== 8'd0) begin errors++; $display("FAIL reset_idx got=%h exp=0", mem_r_address); end
        rst = 1'b0;
    endtask

    task automatic test_word_store_load;
        int lat, nw; logic [31:0] d; logic f; logic [ADDR_W-1:0] wa;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, d, f, nw, wa);
        checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (nw != 1 || wa !== 8'd4) begin errors++; $display("FAIL sw_write got n=%0d idx=%0d exp n=1 idx=4", nw, wa); end
        checks++; if (f !== 1'b0 || d !== 32'd0) begin errors++; $display("FAIL sw_resp got f=%b d=%h exp f=0 d=0", f, d); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, d, f, nw, wa);
        checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        checks++; if (d !== 32'hDEADBEEF || f !== 1'b0) begin errors++; $display("FAIL lw_data got=%h f=%b exp=deadbeef f=0", d, f); end
        checks++; if (nw != 0) begin errors++; $display("FAIL lw_nowrite got=%0d exp=0", nw); end
    endtask

    task automatic test_byte_store;
        int lat, nw; logic [31:0] d; logic f; logic [ADDR_W-1:0] wa;
        do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFFFF55, lat, d, f, nw, wa);
        checks++; if (lat != 3) begin errors++; $display("FAIL sb_latency got=%0d exp=3", lat); end
        checks++; if (nw != 1 || wa !== 8'd4) begin errors++; $display("FAIL sb_write got n=%0d idx=%0d exp n=1 idx=4", nw, wa); end
        checks++; if (mem[4] !== 32'hDE55BEEF) begin errors++; $display("FAIL sb_mem got=%h exp=de55beef", mem[4]); end
    endtask

    task automatic test_extension;
        int lat, nw; logic [31:0] d; logic f; logic [ADDR_W-1:0] wa;
        do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, lat, d, f, nw, wa);
        checks++; if (d !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb got=%h exp=ffffffef", d); end
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, lat, d, f, nw, wa);
        checks++; if (d !== 32'h000000EF) begin errors++; $display("FAIL lbu got=%h exp=000000ef", d); end
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, d, f, nw, wa);
        checks++; if (d !== 32'hFFFFDE55) begin errors++; $display("FAIL lh got=%h exp=ffffde55", d); end
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, d, f, nw, wa);
        checks++; if (d !== 32'h0000DE55) begin errors++; $display("FAIL lhu got=%h exp=0000de55", d); end
        do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, lat, d, f, nw, wa);
        checks++; if (d !== 32'h00000055) begin errors++; $display("FAIL lbu2 got=%h exp=00000055", d); end
    endtask

    task automatic test_faults;
        logic        wr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
        logic [31:0] ad [4] = '{32'h11, 32'h13, 32'h10, 32'h400};
        int lat, nw; logic [31:0] d; logic f; logic [ADDR_W-1:0] wa;
        for (int i = 0; i < 4; i++) begin
            do_req(wr[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D, lat, d, f, nw, wa);
            checks++;
            if (lat != 1 || f !== 1'b1 || nw != 0 || d !== 32'd0) begin
                errors++;
                $display("FAIL fault_%0d got lat=%0d f=%b nw=%0d d=%h exp lat=1 f=1 nw=0 d=0", i, lat, f, nw, d);
            end
        end
        checks++; if (mem[4] !== 32'hDE55BEEF) begin errors++; $display("FAIL fault_mem got=%h exp=de55beef", mem[4]); end
    endtask

    task automatic test_clk_enable;
        int lat, nw; logic frz_bad;
        mem[8] = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h000000AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nw = 0; frz_bad = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) clk_enable = 1'b0;
            if (k >= 2 && k <= 4) begin
                #1;
                if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_w_enable !== 1'b0 ||
                    mem_r_address !== 8'd8) frz_bad = 1'b1;
            end
            if (k == 4) clk_enable = 1'b1;
            if (mem_w_enable && clk_enable) nw++;
            if (resp_valid) begin lat = k; break; end
        end
        checks++; if (frz_bad) begin errors++; $display("FAIL ce_frozen got=changed exp=held"); end
        checks++; if (lat != 6) begin errors++; $display("FAIL ce_latency got=%0d exp=6", lat); end
        checks++; if (nw != 1) begin errors++; $display("FAIL ce_writes got=%0d exp=1", nw); end
        checks++; if (mem[8] !== 32'h1122AA44) begin errors++; $display("FAIL ce_mem got=%h exp=1122aa44", mem[8]); end
    endtask

    task automatic test_reset_in_write;
        mem[9] = 32'h01020304;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h24; req_wdata = 32'h00000077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);  // ACCESS
        @(negedge clk);  // WRITE
        checks++; if (mem_w_enable !== 1'b1) begin errors++; $display("FAIL rw_in_write got=%b exp=1", mem_w_enable); end
        rst = 1'b1;
        #1;
        checks++; if (mem_w_enable !== 1'b0) begin errors++; $display("FAIL rw_gated got=%b exp=0", mem_w_enable); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rw_state got rdy=%b vld=%b exp rdy=1 vld=0", req_ready, resp_valid); end
        checks++; if (mem[9] !== 32'h01020304) begin errors++; $display("FAIL rw_mem got=%h exp=01020304", mem[9]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        test_reset;
        test_word_store_load;
        test_byte_store;
        test_extension;
        test_faults;
        test_clk_enable;
        test_reset_in_write;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
